pipe_collision: RTL and testbench

Per-frame collision and scoring engine between the pipe field and the bruin position/physics block. Once per 60 Hz frame it snapshots the bruin bounding box and every active pipe, checks axis-aligned overlap one pipe per cycle, and produces the sticky `lose` flag that the bruin block consumes to freeze its motion. It also maintains the score from pipes that have fully passed the bruin. Runs entirely in the `clk_100MHz` domain.

---
 rtl/flappy_pkg.sv | 38 +++
 rtl/pipe_collision_if.sv | 31 +++
 rtl/pipe_collision_box_overlap.sv | 33 +++
 rtl/pipe_collision.sv | 136 +++++++++++++
 tb/tb_pipe_collision.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game blocks.
// Holds the collision FSM states, the bruin box payload and the screen/pipe defaults.
package flappy_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned SCORE_W  = 8;
    localparam int unsigned COORD_W  = 11;

    localparam logic [9:0] PIPE_W_DEF   = 10'd40;
    localparam logic [8:0] GAP_HALF_DEF = 9'd50;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } coll_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] l;
        logic [COORD_W-1:0] r;
        logic [COORD_W-1:0] t;
        logic [COORD_W-1:0] b;
    } box_t;

    // Bruin bounding box from centre and size; halves truncate, arithmetic wraps at 11 bits.
    function automatic box_t make_box(input logic [8:0] x, input logic [8:0] y,
                                      input logic [4:0] h, input logic [4:0] w);
        box_t bx;
        bx.l = COORD_W'(x) - COORD_W'(w >> 1);
        bx.r = COORD_W'(x) + COORD_W'(w >> 1);
        bx.t = COORD_W'(y) - COORD_W'(h >> 1);
        bx.b = COORD_W'(y) + COORD_W'(h >> 1);
        return bx;
    endfunction

endpackage

// File: rtl/pipe_collision_if.sv
// Bus between the pipe field / bruin block and the collision engine.
// master drives the game state, slave is the collision engine.
interface pipe_collision_if #(
    parameter int unsigned NUM_PIPES = 4
) ();
    logic                       clk_60Hz;
    logic                       game_start;
    logic                       game_over;
    logic [8:0]                 bruin_x;
    logic [8:0]                 bruin_y;
    logic [4:0]                 high;
    logic [4:0]                 width;
    logic [NUM_PIPES-1:0]       pipe_valid;
    logic [NUM_PIPES-1:0][9:0]  pipe_x;
    logic [NUM_PIPES-1:0][8:0]  pipe_gap_y;
    logic                       lose;
    logic [7:0]                 score;
    logic                       busy;

    modport master (
        output clk_60Hz, game_start, game_over, bruin_x, bruin_y, high, width,
               pipe_valid, pipe_x, pipe_gap_y,
        input  lose, score, busy
    );

    modport slave (
        input  clk_60Hz, game_start, game_over, bruin_x, bruin_y, high, width,
               pipe_valid, pipe_x, pipe_gap_y,
        output lose, score, busy
    );
endinterface

// File: rtl/pipe_collision_box_overlap.sv
// Combinational test of one pipe slot against the latched bruin box.
// Reports a collision, a "fully passed" condition and a "recycled to the right" condition.
module box_overlap
    import flappy_pkg::*;
#(
    parameter logic [9:0] PIPE_W   = PIPE_W_DEF,
    parameter logic [8:0] GAP_HALF = GAP_HALF_DEF
) (
    input  box_t       box_i,
    input  logic [9:0] pipe_x_i,
    input  logic [8:0] gap_y_i,
    output logic       hit_c_o,
    output logic       pass_c_o,
    output logic       recycle_c_o
);
    logic [COORD_W-1:0] px_l;
    logic [COORD_W-1:0] px_r;
    logic [COORD_W-1:0] gap_t;
    logic [COORD_W-1:0] gap_b;
    logic               h_ovl;

    always_comb begin
        px_l  = COORD_W'(pipe_x_i);
        px_r  = px_l + COORD_W'(PIPE_W);
        // Gap top clamps at row 0 instead of wrapping.
        gap_t = (gap_y_i >= GAP_HALF) ? COORD_W'(gap_y_i - GAP_HALF) : '0;
        gap_b = COORD_W'(gap_y_i) + COORD_W'(GAP_HALF);
        h_ovl = (px_l <= box_i.r) && (px_r >= box_i.l);
        hit_c_o     = h_ovl && ((box_i.t < gap_t) || (box_i.b > gap_b));
        pass_c_o    = px_r < box_i.l;
        recycle_c_o = px_l > box_i.r;
    end
endmodule

// File: rtl/pipe_collision.sv
// Per-frame collision and scoring engine: snapshots bruin and pipes on each frame tick,
// checks one slot per cycle, then commits the sticky lose flag and saturating score.
module pipe_collision
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES = 4,
    parameter logic [9:0]  PIPE_W    = PIPE_W_DEF,
    parameter logic [8:0]  GAP_HALF  = GAP_HALF_DEF
) (
    input logic              clk_100MHz,
    input logic              rst,
    pipe_collision_if.slave  bus
);
    localparam int unsigned IDX_W  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int unsigned PEND_W = $clog2(NUM_PIPES + 1);
    localparam int unsigned SUM_W  = SCORE_W + 1;

    coll_state_t                state_q;
    logic [1:0]                 sync_q;
    logic                       prev_q;
    logic                       frame_tick;

    box_t                       box_q;
    logic [NUM_PIPES-1:0]       valid_q;
    logic [NUM_PIPES-1:0][9:0]  px_q;
    logic [NUM_PIPES-1:0][8:0]  gy_q;
    logic                       go_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       hit_acc_q;
    logic [PEND_W-1:0]          pend_q;
    logic [NUM_PIPES-1:0]       passed_q;

    logic                       lose_q;
    logic [SCORE_W-1:0]         score_q;
    logic                       busy_q;

    logic                       slot_hit_c;
    logic                       slot_pass_c;
    logic                       slot_recycle_c;
    logic [SUM_W-1:0]           score_sum_c;
    logic [SCORE_W-1:0]         score_d;

    assign frame_tick = sync_q[1] & ~prev_q;

    box_overlap #(
        .PIPE_W   (PIPE_W),
        .GAP_HALF (GAP_HALF)
    ) u_box_overlap (
        .box_i       (box_q),
        .pipe_x_i    (px_q[idx_q]),
        .gap_y_i     (gy_q[idx_q]),
        .hit_c_o     (slot_hit_c),
        .pass_c_o    (slot_pass_c),
        .recycle_c_o (slot_recycle_c)
    );

    always_comb begin
        score_sum_c = {1'b0, score_q} + SUM_W'(pend_q);
        score_d     = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            box_q     <= '0;
            valid_q   <= '0;
            px_q      <= '0;
            gy_q      <= '0;
            go_q      <= 1'b0;
            idx_q     <= '0;
            hit_acc_q <= 1'b0;
            pend_q    <= '0;
            passed_q  <= '0;
            lose_q    <= 1'b0;
            score_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            // clk_60Hz is asynchronous data: synchronise then detect its rising edge.
            sync_q <= {sync_q[0], bus.clk_60Hz};
            prev_q <= sync_q[1];

            unique case (state_q)
                ST_IDLE: begin
                    if (frame_tick && bus.game_start && !lose_q) begin
                        state_q <= ST_LATCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    box_q     <= make_box(bus.bruin_x, bus.bruin_y, bus.high, bus.width);
                    valid_q   <= bus.pipe_valid;
                    px_q      <= bus.pipe_x;
                    gy_q      <= bus.pipe_gap_y;
                    go_q      <= bus.game_over;
                    idx_q     <= '0;
                    hit_acc_q <= 1'b0;
                    pend_q    <= '0;
                    state_q   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (valid_q[idx_q]) begin
                        hit_acc_q <= hit_acc_q | slot_hit_c;
                        // A slot scores once; it re-arms only after moving back right of the bruin.
                        if (slot_recycle_c) begin
                            passed_q[idx_q] <= 1'b0;
                        end else if (slot_pass_c && !passed_q[idx_q]) begin
                            passed_q[idx_q] <= 1'b1;
                            pend_q          <= pend_q + PEND_W'(1);
                        end
                    end else begin
                        passed_q[idx_q] <= 1'b0;
                    end
                    if (idx_q == IDX_W'(NUM_PIPES - 1)) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    lose_q  <= lose_q | hit_acc_q | go_q;
                    score_q <= score_d;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.lose  = lose_q;
    assign bus.score = score_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_pipe_collision.sv
// Randomised and directed bench for pipe_collision against a frame-level reference model.
module tb_pipe_collision;
    localparam int N  = 4;
    localparam int PW = 40;
    localparam int GH = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_collision_if #(.NUM_PIPES(N)) bus ();

    pipe_collision #(.NUM_PIPES(N)) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cycles = 0;

    // Reference model: frame timing as a countdown, frame outcome computed in one step.
    bit m_on = 0;
    bit h0, h1, h2, tick;
    int m_cnt = 0;
    bit m_lose = 0;
    int m_score = 0;
    bit m_passed [N];
    bit pend_hit, pend_go;
    int pend_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void eval_frame();
        int L, R, T, B, px, gy, gt, gb;
        L = (int'(bus.bruin_x) - int'(bus.width) / 2) & 'h7FF;
        R = (int'(bus.bruin_x) + int'(bus.width) / 2) & 'h7FF;
        T = (int'(bus.bruin_y) - int'(bus.high) / 2) & 'h7FF;
        B = (int'(bus.bruin_y) + int'(bus.high) / 2) & 'h7FF;
        pend_hit = 0;
        pend_cnt = 0;
        pend_go  = bus.game_over;
        for (int s = 0; s < N; s++) begin
            if (!bus.pipe_valid[s]) begin
                m_passed[s] = 0;
                continue;
            end
            px = int'(bus.pipe_x[s]);
            gy = int'(bus.pipe_gap_y[s]);
            gt = (gy >= GH) ? gy - GH : 0;
            gb = gy + GH;
            if (px <= R && px + PW >= L && (T < gt || B > gb)) pend_hit = 1;
            if (px > R) m_passed[s] = 0;
            else if (px + PW < L && !m_passed[s]) begin
                m_passed[s] = 1;
                pend_cnt++;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1;
            h0 = 0; h1 = 0; h2 = 0;
            m_cnt = 0; m_lose = 0; m_score = 0;
            for (int s = 0; s < N; s++) m_passed[s] = 0;
        end else begin
            tick = h1 & ~h2;
            h2 = h1; h1 = h0; h0 = bus.clk_60Hz;
            if (m_cnt == 0) begin
                if (tick && bus.game_start && !m_lose) m_cnt = N + 2;
            end else begin
                if (m_cnt == N + 2) eval_frame();
                m_cnt--;
                if (m_cnt == 0) begin
                    m_lose  = m_lose | pend_hit | pend_go;
                    m_score = (m_score + pend_cnt > 255) ? 255 : m_score + pend_cnt;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("busy",  32'(bus.busy),  32'(m_cnt != 0));
            check("lose",  32'(bus.lose),  32'(m_lose));
            check("score", 32'(bus.score), 32'(m_score));
            if (bus.busy === 1'b1) busy_cycles++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        bus.clk_60Hz = 1'b1;
        cycles(4);
        bus.clk_60Hz = 1'b0;
        cycles(12);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic all_pipes(input logic [9:0] x, input logic [8:0] gy);
        for (int s = 0; s < N; s++) begin
            bus.pipe_x[s]     = x;
            bus.pipe_gap_y[s] = gy;
        end
    endtask

    task automatic randomize_inputs();
        bus.bruin_x = 9'($urandom_range(150, 250));
        bus.bruin_y = 9'($urandom_range(40, 440));
        bus.width   = 5'($urandom_range(0, 31));
        bus.high    = 5'($urandom_range(0, 31));
        bus.pipe_valid = N'($urandom);
        for (int s = 0; s < N; s++) begin
            bus.pipe_x[s]     = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(600, 1023))
                                                            : 10'($urandom_range(100, 300));
            bus.pipe_gap_y[s] = 9'($urandom_range(0, 480));
        end
        bus.game_start = ($urandom_range(0, 7) != 0);
        bus.game_over  = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        bus.clk_60Hz   = 1'b0;
        bus.game_start = 1'b1;
        bus.game_over  = 1'b0;
        bus.bruin_x    = 9'd200;
        bus.bruin_y    = 9'd240;
        bus.width      = 5'd20;
        bus.high       = 5'd20;
        bus.pipe_valid = '0;
        all_pipes(10'd600, 9'd240);
        cycles(3);
        rst = 1'b0;
        cycles(1);
        check("reset_lose",  32'(bus.lose),  32'd0);
        check("reset_score", 32'(bus.score), 32'd0);
        check("reset_busy",  32'(bus.busy),  32'd0);

        // Clear pipe: no hit, no pass, busy for N+2 cycles.
        bus.pipe_valid = 4'b0001;
        bus.pipe_x[0] = 10'd300; bus.pipe_gap_y[0] = 9'd240;
        busy_cycles = 0;
        frame();
        check("clear_busy_len", 32'(busy_cycles), 32'(N + 2));
        check("clear_lose",     32'(bus.lose),    32'd0);
        check("clear_score",    32'(bus.score),   32'd0);

        // Overlapping pipe with bruin above the gap: lose sticks, later frames ignored.
        bus.pipe_x[0] = 10'd195; bus.pipe_gap_y[0] = 9'd300;
        frame();
        check("hit_lose", 32'(bus.lose), 32'd1);
        busy_cycles = 0;
        frame();
        check("hit_frozen_busy", 32'(busy_cycles), 32'd0);
        check("hit_sticky_lose", 32'(bus.lose),    32'd1);
        do_reset();
        check("rst_lose", 32'(bus.lose), 32'd0);

        // Passing and recycling a pipe.
        bus.pipe_x[0] = 10'd140; bus.pipe_gap_y[0] = 9'd240;
        frame();
        check("pass_1", 32'(bus.score), 32'd1);
        frame();
        check("pass_once", 32'(bus.score), 32'd1);
        bus.pipe_x[0] = 10'd600;
        frame();
        bus.pipe_x[0] = 10'd140;
        frame();
        check("pass_2", 32'(bus.score), 32'd2);

        // Saturation at 255.
        do_reset();
        bus.pipe_valid = 4'b1111;
        for (int f = 0; f < 63; f++) begin
            all_pipes(10'd600, 9'd240); frame();
            all_pipes(10'd140, 9'd240); frame();
        end
        check("sat_252", 32'(bus.score), 32'd252);
        all_pipes(10'd600, 9'd240); frame();
        bus.pipe_valid = 4'b0111;
        all_pipes(10'd140, 9'd240); frame();
        check("sat_255", 32'(bus.score), 32'd255);
        all_pipes(10'd600, 9'd240); frame();
        bus.pipe_valid = 4'b0001;
        all_pipes(10'd140, 9'd240); frame();
        check("sat_hold", 32'(bus.score), 32'd255);
        check("sat_lose", 32'(bus.lose),  32'd0);

        // game_over forces lose; game_start low ignores ticks.
        do_reset();
        bus.pipe_valid = '0;
        bus.game_over = 1'b1;
        frame();
        check("go_lose", 32'(bus.lose), 32'd1);
        bus.game_over = 1'b0;
        do_reset();
        bus.game_start = 1'b0;
        bus.pipe_valid = 4'b0001;
        bus.pipe_x[0] = 10'd140;
        busy_cycles = 0;
        frame(); frame();
        check("nostart_busy",  32'(busy_cycles), 32'd0);
        check("nostart_score", 32'(bus.score),   32'd0);

        // Reset in the middle of CHECK discards everything.
        bus.game_start = 1'b1;
        frame();
        check("pre_rst_score", 32'(bus.score), 32'd1);
        bus.pipe_x[0] = 10'd600; frame();
        bus.pipe_x[0] = 10'd140;
        bus.game_over = 1'b1;
        bus.clk_60Hz = 1'b1;
        cycles(5);
        check("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        bus.clk_60Hz = 1'b0;
        bus.game_over = 1'b0;
        check("mid_rst_busy",  32'(bus.busy),  32'd0);
        check("mid_rst_lose",  32'(bus.lose),  32'd0);
        check("mid_rst_score", 32'(bus.score), 32'd0);
        cycles(14);

        // Random frames with inputs perturbed during the frame.
        for (int f = 0; f < 200; f++) begin
            randomize_inputs();
            bus.clk_60Hz = 1'b1;
            cycles($urandom_range(1, 6));
            randomize_inputs();
            bus.clk_60Hz = 1'b0;
            cycles($urandom_range(2, 14));
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1; cycles(1); rst = 1'b0;
            end
            if (bus.lose === 1'b1 && $urandom_range(0, 1) == 0) do_reset();
        end
        cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
